// File: rtl/sp_ram_burst_reader_if.sv
// RAM port plus output stream of the burst reader.
// master = reader side, slave = RAM + stream consumer side.
interface sp_ram_burst_reader_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   localparam int BYTES = DATA_WIDTH / 8;

   logic                  mem_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [BYTES-1:0]      mem_be;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;
   logic                  last;

   modport master (
      output mem_en, mem_addr, mem_we, mem_be, mem_wdata,
      input  mem_rdata,
      output data, valid, last,
      input  ready
   );

   modport slave (
      input  mem_en, mem_addr, mem_we, mem_be, mem_wdata,
      output mem_rdata,
      input  data, valid, last,
      output ready
   );
endinterface

// File: rtl/sp_ram_burst_reader.sv
// Reads num_words contiguous words from a single-port RAM into a valid/ready stream.
// Optional backpressure counter: define SP_RAM_READER_STALL_CNT_EN.
module sp_ram_burst_reader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [LEN_WIDTH-1:0]  num_words_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [LEN_WIDTH-1:0]  stall_cnt_o,
   sp_ram_burst_reader_if.master bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e                state_q;
   logic                  busy_q, done_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  num_q, issued_q, popped_q;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic                  wptr_q, rptr_q;
   logic [1:0]            cnt_q, cnt_d;
   logic [2:0]            occ;
   logic                  pop, issue, last_hd;

   // Words held or on their way must leave room for the next read's return data.
   always_comb begin
      pop     = (cnt_q != 2'd0) && bus.ready;
      occ     = {1'b0, cnt_q} + {2'b0, inflight_q};
      issue   = (state_q == S_RUN) && (issued_q < num_q) &&
                (occ < (pop ? 3'd3 : 3'd2));
      last_hd = (popped_q == num_q - LEN_WIDTH'(1));
      cnt_d   = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_q     <= '0;
         num_q      <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         inflight_q <= 1'b0;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
         cnt_q      <= 2'd0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= issue;
         cnt_q      <= cnt_d;
         if (issue) begin
            addr_q   <= addr_q + STEP;
            issued_q <= issued_q + LEN_WIDTH'(1);
         end
         if (pop) begin
            popped_q <= popped_q + LEN_WIDTH'(1);
            rptr_q   <= ~rptr_q;
         end
         // RAM data is only meaningful the cycle after an issue.
         if (inflight_q) begin
            fifo_q[wptr_q] <= bus.mem_rdata;
            wptr_q         <= ~wptr_q;
         end
         case (state_q)
            S_IDLE: if (start_i) begin
               addr_q   <= base_addr_i & ALIGN_MASK;
               num_q    <= num_words_i;
               issued_q <= '0;
               popped_q <= '0;
               if (num_words_i != '0) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
               end else begin
                  done_q  <= 1'b1;
               end
            end
            S_RUN: if (pop && last_hd) begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef SP_RAM_READER_STALL_CNT_EN
   logic [LEN_WIDTH-1:0] stall_q;
   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_q <= '0;
      else if (state_q == S_IDLE && start_i)
         stall_q <= '0;
      else if (bus.valid && !bus.ready && stall_q != '1)
         stall_q <= stall_q + LEN_WIDTH'(1);
   end
   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = '0;
`endif

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign bus.mem_en    = issue;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_we    = 1'b0;
   assign bus.mem_be    = '1;
   assign bus.mem_wdata = '0;
   assign bus.valid     = (cnt_q != 2'd0);
   assign bus.data      = fifo_q[rptr_q];
   assign bus.last      = bus.valid && last_hd;
endmodule

// File: tb/tb_sp_ram_burst_reader.sv
// Scoreboard bench for sp_ram_burst_reader: a RAM model, random backpressure and a
// per-burst expected address/beat list computed from base + 4*i with 8-bit wrap.
module tb_sp_ram_burst_reader;
   localparam int AW = 8, DW = 32, LW = 16;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [AW-1:0] base = '0;
   logic [LW-1:0] nw = '0;
   logic          busy, done;
   logic [LW-1:0] stall;

   sp_ram_burst_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

   sp_ram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base),
      .num_words_i(nw), .busy_o(busy), .done_o(done), .stall_cnt_o(stall),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   // RAM: registered read; rdata changes every cycle, garbage when not enabled.
   logic [DW-1:0] ram [64];
   always @(posedge clk)
      bus_if.mem_rdata <= bus_if.mem_en ? ram[bus_if.mem_addr[AW-1:2]] : DW'($urandom);

   typedef struct { logic [DW-1:0] d; logic l; } beat_t;
   beat_t         exp_q[$];
   logic [AW-1:0] addr_q[$];

   int n_pass = 0, n_chk = 0;
   int en_cnt, done_cnt, pop_cnt, stall_seen;
   bit busy_seen, rdy_rand = 1'b0, prev_stall = 1'b0;
   logic [DW-1:0] prev_data;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   initial begin
      bus_if.ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus_if.ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: consumes the scoreboard on every issue and every handshake.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (busy) busy_seen = 1'b1;
         if (done) done_cnt++;
         if (bus_if.mem_en) begin
            en_cnt++;
            if (addr_q.size() != 0) chk("addr", 64'(bus_if.mem_addr), 64'(addr_q.pop_front()));
            else chk("extra_issue", 1, 0);
            chk("tied", {bus_if.mem_we, bus_if.mem_be, bus_if.mem_wdata}, {1'b0, 4'hF, 32'h0});
         end
         if (prev_stall) chk("hold", {bus_if.valid, bus_if.data}, {1'b1, prev_data});
         if (bus_if.valid && !bus_if.ready) stall_seen++;
         if (bus_if.valid && bus_if.ready) begin
            pop_cnt++;
            if (exp_q.size() != 0) begin
               beat_t e;
               e = exp_q.pop_front();
               chk("data", 64'(bus_if.data), 64'(e.d));
               chk("last", 64'(bus_if.last), 64'(e.l));
            end else chk("extra_beat", 1, 0);
         end
         prev_stall = bus_if.valid && !bus_if.ready;
         prev_data  = bus_if.data;
      end else prev_stall = 1'b0;
   end

   task automatic push_burst(input logic [AW-1:0] b, input int n);
      logic [AW-1:0] a;
      beat_t e;
      for (int i = 0; i < n; i++) begin
         a = (b & 8'hFC) + AW'(4 * i);
         addr_q.push_back(a);
         e.d = ram[a[AW-1:2]];
         e.l = (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic run_burst(input logic [AW-1:0] b, input int n, input bit rnd, input string tag);
      int cyc, fv;
      bit ok;
      rdy_rand = rnd;
      en_cnt = 0; done_cnt = 0; stall_seen = 0; busy_seen = 1'b0;
      push_burst(b, n);
      @(posedge clk); #1;
      start = 1'b1; base = b; nw = LW'(n);
      @(posedge clk); #1;
      start = 1'b0; base = AW'($urandom); nw = LW'($urandom);
      cyc = 0; ok = 1'b0; fv = 0;
      while (cyc < 2000 && !ok) begin
         @(negedge clk); #1;
         cyc++;
         if (bus_if.valid && fv == 0) fv = cyc;
         if (done) ok = 1'b1;
      end
      chk({tag, " done_seen"}, 64'(ok), 1);
      if (n == 0) chk({tag, " n0_done_lat"}, 64'(cyc), 1);
      else chk({tag, " first_valid_lat"}, 64'(fv), 3);
      if (!rnd && n != 0) chk({tag, " done_lat"}, 64'(cyc), 64'(n + 3));
      repeat (3) @(negedge clk);
      #1;
      chk({tag, " issues"}, 64'(en_cnt), 64'(n));
      chk({tag, " done_pulses"}, 64'(done_cnt), 1);
      chk({tag, " beats_left"}, 64'(exp_q.size() + addr_q.size()), 0);
      chk({tag, " busy_seen"}, 64'(busy_seen), 64'(n != 0));
`ifdef SP_RAM_READER_STALL_CNT_EN
      chk({tag, " stall_cnt"}, 64'(stall), 64'(stall_seen));
`else
      chk({tag, " stall_cnt"}, 64'(stall), 0);
`endif
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = (i < 8) ? DW'(32'hA0 + i) : DW'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ctl", {busy, done, bus_if.mem_en, bus_if.valid, bus_if.last}, 0);
      chk("reset_addr", 64'(bus_if.mem_addr), 0);
      chk("reset_stall", 64'(stall), 0);
      rst_n = 1'b1;

      run_burst(8'h00, 8, 1'b0, "T1");
      run_burst(8'h00, 8, 1'b1, "T2");
      run_burst(8'hF8, 4, 1'b1, "T3");
      run_burst(8'h40, 0, 1'b0, "T4");

      // T5: reset after 3 beats aborts silently.
      rdy_rand = 1'b0; done_cnt = 0; pop_cnt = 0;
      push_burst(8'h00, 8);
      @(posedge clk); #1;
      start = 1'b1; base = 8'h00; nw = 8;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 100 && pop_cnt < 3; c++) begin
         @(negedge clk); #1;
      end
      chk("T5 three_beats", 64'(pop_cnt), 3);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("T5 reset_ctl", {busy, done, bus_if.mem_en, bus_if.valid, bus_if.last}, 0);
      chk("T5 reset_addr", 64'(bus_if.mem_addr), 0);
      chk("T5 no_done", 64'(done_cnt), 0);
      exp_q.delete(); addr_q.delete();
      rst_n = 1'b1;
      run_burst(8'h10, 2, 1'b0, "T5");

      // T6: second start mid-burst must be ignored.
      fork
         run_burst(8'h20, 6, 1'b1, "T6");
         begin
            repeat (4) @(posedge clk);
            #1; start = 1'b1; base = 8'h80; nw = 3;
            @(posedge clk); #1; start = 1'b0;
         end
      join

      for (int k = 0; k < 4; k++)
         run_burst(AW'($urandom), $urandom_range(1, 10), 1'b1, "RND");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
